// File: rtl/fifo_param_if.sv
// Handshake and status bundle between a FIFO client and fifo_param.
// The client drives through master; the FIFO answers through slave.
interface fifo_param_if #(
    parameter int DATA_SIZE = 10,
    parameter int ADDR_SIZE = 3
);
    logic                 write;
    logic                 read;
    logic [DATA_SIZE-1:0] data_in_push;
    logic [ADDR_SIZE:0]   th_full;
    logic [ADDR_SIZE:0]   th_empty;
    logic                 error_clear;

    logic [DATA_SIZE-1:0] data_out_pop;
    logic                 valid_out;
    logic [ADDR_SIZE:0]   fifo_count;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 almost_full;
    logic                 almost_empty;
    logic                 fifo_pause;
    logic                 fifo_error;
    logic                 err_overflow;
    logic                 err_underflow;

    modport master (
        output write, read, data_in_push, th_full, th_empty, error_clear,
        input  data_out_pop, valid_out, fifo_count, fifo_empty, fifo_full,
               almost_full, almost_empty, fifo_pause, fifo_error,
               err_overflow, err_underflow
    );

    modport slave (
        input  write, read, data_in_push, th_full, th_empty, error_clear,
        output data_out_pop, valid_out, fifo_count, fifo_empty, fifo_full,
               almost_full, almost_empty, fifo_pause, fifo_error,
               err_overflow, err_underflow
    );
endinterface

// File: rtl/fifo_param.sv
// Single-clock FIFO with programmable almost-full/empty thresholds, a
// hysteretic pause output and sticky overflow/underflow flags.
module fifo_param #(
    parameter int DATA_SIZE = 10,
    parameter int ADDR_SIZE = 3
) (
    input  logic        clk,
    input  logic        reset,
    fifo_param_if.slave bus
);
    localparam int                 DEPTH      = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] FULL_COUNT = (ADDR_SIZE + 1)'(DEPTH);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_SIZE:0]   count_q, count_d;
    logic [DATA_SIZE-1:0] dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 pause_q, pause_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;

    logic empty, full, rd_acc, wr_acc;

    assign empty  = (count_q == '0);
    assign full   = (count_q == FULL_COUNT);
    assign rd_acc = bus.read & ~empty;
    // A push into a full FIFO only fits when a pop frees a slot this cycle.
    assign wr_acc = bus.write & (~full | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q + ADDR_SIZE'(wr_acc);
        rd_ptr_d = rd_ptr_q + ADDR_SIZE'(rd_acc);
        count_d  = count_q + (ADDR_SIZE + 1)'(wr_acc) - (ADDR_SIZE + 1)'(rd_acc);
        dout_d   = rd_acc ? mem_q[rd_ptr_q] : dout_q;
        valid_d  = rd_acc;

        // Set wins over clear when the thresholds overlap.
        pause_d = pause_q;
        if (count_d >= bus.th_full) begin
            pause_d = 1'b1;
        end else if (count_d <= bus.th_empty) begin
            pause_d = 1'b0;
        end

        ovf_d = (bus.write & ~wr_acc) | (ovf_q & ~bus.error_clear);
        udf_d = (bus.read & ~rd_acc) | (udf_q & ~bus.error_clear);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            pause_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            pause_q  <= pause_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage has no reset: count and pointers alone define which words are live.
    always_ff @(posedge clk) begin
        if (reset && wr_acc) begin
            mem_q[wr_ptr_q] <= bus.data_in_push;
        end
    end

    assign bus.data_out_pop  = dout_q;
    assign bus.valid_out     = valid_q;
    assign bus.fifo_count    = count_q;
    assign bus.fifo_empty    = empty;
    assign bus.fifo_full     = full;
    assign bus.almost_full   = (count_q >= bus.th_full);
    assign bus.almost_empty  = (count_q <= bus.th_empty);
    assign bus.fifo_pause    = pause_q;
    assign bus.err_overflow  = ovf_q;
    assign bus.err_underflow = udf_q;
    assign bus.fifo_error    = ovf_q | udf_q;
endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised single-clock synchronous FIFO for the PCIe switching datapath, generalising the fixed 10-bit × 8-entry FIFO. It adds configurable width and depth, run-time programmable almost-full/almost-empty thresholds, an occupancy count, and a pause output with hysteresis. It also adds sticky overflow/underflow error reporting with a synchronous clear. It sits between the switch's ingress logic and the downstream scheduler, which uses `fifo_pause` as backpressure.

## Interface
- `DATA_SIZE`, 10, word width in bits
- `ADDR_SIZE`, 3, pointer width; depth = 2^ADDR_SIZE (8)
- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-low reset
- `write`  in  1  push request
- `read`  in  1  pop request
- `data_in_push`  in  DATA_SIZE  push data
- `th_full`  in  ADDR_SIZE+1  almost-full threshold
- `th_empty`  in  ADDR_SIZE+1  almost-empty threshold
- `error_clear`  in  1  clears sticky error flags
- `data_out_pop`  out  DATA_SIZE  popped word, registered
- `valid_out`  out  1  `data_out_pop` updated this cycle
- `fifo_count`  out  ADDR_SIZE+1  occupancy, 0..2^ADDR_SIZE
- `fifo_empty`  out  1  count == 0
- `fifo_full`  out  1  count == 2^ADDR_SIZE
- `almost_full`  out  1  count >= th_full
- `almost_empty`  out  1  count <= th_empty
- `fifo_pause`  out  1  backpressure with hysteresis
- `fifo_error`  out  1  OR of the sticky errors
- `err_overflow`  out  1  sticky: write rejected while full
- `err_underflow`  out  1  sticky: read rejected while empty

## Operation
- **Storage:** 2^ADDR_SIZE × DATA_SIZE register array. `wr_ptr` and `rd_ptr` are ADDR_SIZE bits and wrap naturally from 2^ADDR_SIZE−1 to 0. The count register is ADDR_SIZE+1 bits.
- **Read accept:** `rd_acc = read & ~fifo_empty`.
- **Write accept:** `wr_acc = write & (~fifo_full | rd_acc)`. A push while full is accepted only if a pop is accepted in the same cycle.
- **Count update:** `count_next = count + wr_acc − rd_acc`.
- **Simultaneous read+write while empty:** the read is rejected (no bypass) and the write is accepted, so count becomes 1. `err_underflow` is set.
- **Simultaneous read+write while full:** both are accepted and count is unchanged.
- **Pop:** on `rd_acc`, `data_out_pop <= mem[rd_ptr]` and `valid_out <= 1`. Otherwise `data_out_pop` holds its value and `valid_out <= 0`.
- **Flags:** `fifo_empty`, `fifo_full`, `almost_full` and `almost_empty` are combinational from the count register. Thresholds are sampled live, so a threshold change affects the flags in the same cycle.
- **Pause (registered, hysteresis):**
  - If `count_next >= th_full`, `fifo_pause <= 1`.
  - Else if `count_next <= th_empty`, `fifo_pause <= 0`.
  - Otherwise `fifo_pause` holds.
  - Set has priority when the thresholds overlap.
- **Errors:**
  - `write & ~wr_acc` sets `err_overflow`.
  - `read & ~rd_acc` sets `err_underflow`.
  - Both are sticky. `error_clear` clears them, but a new error in the same cycle wins and the flag stays set.
  - `fifo_error = err_overflow | err_underflow`.
  - A rejected operation never changes pointers, count or memory.
- **Reset** (`reset == 0` at a rising edge, any time including mid-operation):
  - Pointers and count become 0 and contents are discarded.
  - `data_out_pop` = 0, `valid_out` = 0, `fifo_pause` = 0, and both errors = 0.
  - Derived flags after reset: `fifo_empty` = 1, `fifo_full` = 0, `almost_empty` = 1 (for any `th_empty`), `almost_full` = (`th_full` == 0).
  - Requests in the reset cycle are ignored and set no error.

## Timing
- **Write to read:** a word written at edge N can be popped by a `read` at edge N+1, and appears on `data_out_pop` after edge N+1.
- **Read latency:** 1 cycle from the accepting edge; `valid_out` is high exactly one cycle per accepted pop.
- **Status outputs:** `fifo_count` and the four derived flags reflect the state after each edge, with 0 cycles of extra delay.
- **`fifo_pause`:** changes at the same edge as the count that crosses a threshold.
- **Throughput:** one push and one pop per cycle sustained; a full FIFO with continuous read+write never stalls.

## Test plan
- **Reset:** apply reset for 2 cycles with `write=1`, `read=1` -> count 0, `fifo_empty=1`, `almost_empty=1`, all errors 0, `data_out_pop=0`.
- **Fill and drain:** DATA_SIZE=10, ADDR_SIZE=3, `th_full=6`, `th_empty=2`.
  - Push 0x001..0x008 -> `almost_full` rises at count 6 and `fifo_full` at count 8.
  - A 9th push sets `err_overflow`, with count still 8.
  - Drain 8 pops -> outputs 0x001..0x008 in order, each 1 cycle after its pop with `valid_out=1`.
- **Pause hysteresis:** with the same thresholds, fill to 6 -> `fifo_pause=1`. Pop down to 3 -> still 1. Pop to 2 -> 0.
- **Empty boundary:** read with write while empty -> count 1, `err_underflow=1`, `valid_out=0`. Assert `error_clear` -> `fifo_error=0` next cycle.
- **Full boundary and wrap:** read+write every cycle while full for 20 cycles -> count stays 8, output order preserved across pointer wrap, no error.
- **Reset mid-operation:** reset at count 5 -> count 0 next cycle. A subsequent push/pop returns the new data, not stale data.
